// File: rtl/crc32_stream_pkg.sv
// crc_pkg: shared FSM state type, IEEE CRC-32 constants and the reflected per-byte CRC update.
package crc_pkg;

    typedef enum logic [1:0] {S_WAIT, S_CALC, S_OUT} state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    // LSb-first: bit 0 of the byte enters the register first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b, input logic [31:0] poly);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ poly) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// crc32_stream_if: input beat and result handshakes of the streaming CRC-32 engine.
interface crc32_stream_if #(
    parameter int BEAT_BYTES = 8,
    parameter int LEN_W      = 16
);
    localparam int NB_W = $clog2(BEAT_BYTES + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic [8*BEAT_BYTES-1:0] in_data;
    logic                    in_last;
    logic [NB_W-1:0]         in_nbytes;
    logic                    check_en;
    logic [31:0]             exp_crc;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_crc;
    logic [LEN_W-1:0]        out_len;
    logic                    out_match;

    modport master (
        output in_valid, in_data, in_last, in_nbytes, check_en, exp_crc, out_ready,
        input  in_ready, out_valid, out_crc, out_len, out_match
    );

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, check_en, exp_crc, out_ready,
        output in_ready, out_valid, out_crc, out_len, out_match
    );

endinterface

// File: rtl/crc32_stream_slice.sv
// crc32_slice: combinational fold of N bytes (MSB lane first); en_i gates the partial tail.
module crc32_slice
    import crc_pkg::*;
#(
    parameter int          N    = 1,
    parameter logic [31:0] POLY = CRC32_POLY_REFL
) (
    input  logic [31:0]    crc_i,
    input  logic [8*N-1:0] data_i,
    input  logic [N-1:0]   en_i,
    output logic [31:0]    crc_o
);

    logic [31:0] c [0:N];

    assign c[0] = crc_i;

    for (genvar g = 0; g < N; g++) begin : g_byte
        assign c[g+1] = en_i[g] ? crc32_byte(c[g], data_i[8*(N-g)-1 -: 8], POLY) : c[g];
    end

    assign crc_o = c[N];

endmodule

// File: rtl/crc32_stream.sv
// crc32_stream: streaming CRC-32 over valid/ready beats, folding BYTES_PER_CYC bytes per clock,
// reporting CRC, saturating byte length and an optional match against an expected CRC.
module crc32_stream
    import crc_pkg::*;
#(
    parameter int          BEAT_BYTES    = 8,
    parameter int          BYTES_PER_CYC = 1,
    parameter logic [31:0] POLY          = CRC32_POLY_REFL,
    parameter logic [31:0] INIT          = CRC32_INIT,
    parameter logic [31:0] XOROUT        = CRC32_XOROUT,
    parameter int          LEN_W         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    crc32_stream_if.slave  bus
);

    localparam int NB_W = $clog2(BEAT_BYTES + 1);
    localparam int DW   = 8 * BEAT_BYTES;

    if (BEAT_BYTES % BYTES_PER_CYC != 0) begin : g_bad_cfg
        $error("BYTES_PER_CYC must divide BEAT_BYTES");
    end

    state_t                 state_q, state_d;
    logic [31:0]            crc_q, crc_d, crc_fold;
    logic [LEN_W-1:0]       len_q, len_d, len_sat;
    logic                   first_q, first_d;
    logic [DW-1:0]          beat_q, beat_d;
    logic [NB_W-1:0]        rem_q, rem_d, k, eff_nb;
    logic                   last_q, last_d;
    logic                   check_en_q, check_en_d;
    logic [31:0]            exp_crc_q, exp_crc_d;
    logic [31:0]            out_crc_q, out_crc_d;
    logic [LEN_W-1:0]       out_len_q, out_len_d;
    logic                   out_match_q, out_match_d;
    logic [BYTES_PER_CYC-1:0] en;
    logic [LEN_W:0]         len_sum;

    assign eff_nb  = (bus.in_nbytes == '0 || bus.in_nbytes > NB_W'(BEAT_BYTES)) ? NB_W'(BEAT_BYTES) : bus.in_nbytes;
    assign k       = (rem_q < NB_W'(BYTES_PER_CYC)) ? rem_q : NB_W'(BYTES_PER_CYC);
    assign len_sum = {1'b0, len_q} + (LEN_W+1)'(k);
    assign len_sat = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

    for (genvar g = 0; g < BYTES_PER_CYC; g++) begin : g_en
        assign en[g] = NB_W'(g) < k;
    end

    crc32_slice #(.N(BYTES_PER_CYC), .POLY(POLY)) u_slice (
        .crc_i  (crc_q),
        .data_i (beat_q[DW-1 -: 8*BYTES_PER_CYC]),
        .en_i   (en),
        .crc_o  (crc_fold)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        len_d       = len_q;
        first_d     = first_q;
        beat_d      = beat_q;
        rem_d       = rem_q;
        last_d      = last_q;
        check_en_d  = check_en_q;
        exp_crc_d   = exp_crc_q;
        out_crc_d   = out_crc_q;
        out_len_d   = out_len_q;
        out_match_d = out_match_q;
        case (state_q)
            S_WAIT: if (bus.in_valid) begin
                beat_d     = bus.in_data;
                rem_d      = bus.in_last ? eff_nb : NB_W'(BEAT_BYTES);
                last_d     = bus.in_last;
                check_en_d = first_q ? bus.check_en : check_en_q;
                exp_crc_d  = bus.in_last ? bus.exp_crc : exp_crc_q;
                first_d    = 1'b0;
                state_d    = S_CALC;
            end
            S_CALC: begin
                crc_d  = crc_fold;
                len_d  = len_sat;
                beat_d = beat_q << (8 * k);
                rem_d  = rem_q - k;
                if (rem_q == k) begin
                    state_d = last_q ? S_OUT : S_WAIT;
                    if (last_q) begin
                        out_crc_d   = crc_fold ^ XOROUT;
                        out_len_d   = len_sat;
                        out_match_d = check_en_q && ((crc_fold ^ XOROUT) == exp_crc_q);
                    end
                end
            end
            S_OUT: if (bus.out_ready) begin
                crc_d   = INIT;
                len_d   = '0;
                first_d = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            crc_q       <= INIT;
            len_q       <= '0;
            first_q     <= 1'b1;
            beat_q      <= '0;
            rem_q       <= '0;
            last_q      <= 1'b0;
            check_en_q  <= 1'b0;
            exp_crc_q   <= '0;
            out_crc_q   <= '0;
            out_len_q   <= '0;
            out_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            first_q     <= first_d;
            beat_q      <= beat_d;
            rem_q       <= rem_d;
            last_q      <= last_d;
            check_en_q  <= check_en_d;
            exp_crc_q   <= exp_crc_d;
            out_crc_q   <= out_crc_d;
            out_len_q   <= out_len_d;
            out_match_q <= out_match_d;
        end
    end

    assign bus.in_ready  = (state_q == S_WAIT);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_crc   = out_crc_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_match = out_match_q;

endmodule

// File: tb/tb_crc32_stream.sv
// tb_crc32_stream: directed checks of crc32_stream with one byte per clock (dut_a)
// and a full beat per clock with a 4-bit length counter (dut_b).
module tb_crc32_stream;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc32_stream_if #(.BEAT_BYTES(8), .LEN_W(16)) a ();
    crc32_stream_if #(.BEAT_BYTES(8), .LEN_W(4))  b ();

    crc32_stream #(.BEAT_BYTES(8), .BYTES_PER_CYC(1), .LEN_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    crc32_stream #(.BEAT_BYTES(8), .BYTES_PER_CYC(8), .LEN_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    logic        sel = 1'b0, in_valid = 1'b0, in_last = 1'b0, check_en = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_nbytes = '0;
    logic [31:0] exp_crc = '0;

    assign a.in_valid  = in_valid & ~sel;
    assign b.in_valid  = in_valid & sel;
    assign a.out_ready = out_ready & ~sel;
    assign b.out_ready = out_ready & sel;
    assign a.in_data   = in_data;
    assign b.in_data   = in_data;
    assign a.in_last   = in_last;
    assign b.in_last   = in_last;
    assign a.in_nbytes = in_nbytes;
    assign b.in_nbytes = in_nbytes;
    assign a.check_en  = check_en;
    assign b.check_en  = check_en;
    assign a.exp_crc   = exp_crc;
    assign b.exp_crc   = exp_crc;

    logic        rdy, ov, om;
    logic [31:0] ocrc;
    logic [15:0] olen;
    assign rdy  = sel ? b.in_ready  : a.in_ready;
    assign ov   = sel ? b.out_valid : a.out_valid;
    assign om   = sel ? b.out_match : a.out_match;
    assign ocrc = sel ? b.out_crc   : a.out_crc;
    assign olen = sel ? {12'b0, b.out_len} : a.out_len;

    int checks = 0, errors = 0, ncyc = 0, hs_cyc = 0, t0 = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    localparam logic [63:0] S1 = 64'h3132333435363738;
    localparam logic [63:0] S2 = 64'h3900000000000000;

    logic [7:0] mem [0:39];

    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ mem[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb, input logic ce, input logic [31:0] ec);
        int t;
        t = 0;
        @(negedge clk);
        in_data = d; in_last = last; in_nbytes = nb; check_en = ce; exp_crc = ec; in_valid = 1'b1;
        while (!rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", {31'b0, rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        hs_cyc = ncyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!ov && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("out_valid_wait", {31'b0, ov}, 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {31'b0, ov}, 32'd0);
        chk("in_ready_after_out", {31'b0, rdy}, 32'd1);
    endtask

    task automatic send_str(input logic ce, input logic [31:0] ec);
        send(S1, 1'b0, 4'd0, ce, 32'h0);
        t0 = hs_cyc;
        send(S2, 1'b1, 4'd1, 1'b0, ec);
        wait_out();
    endtask

    task automatic send_legacy();
        logic [63:0] d;
        for (int i = 0; i < 40; i++) mem[i] = 8'(i);
        for (int i = 0; i < 5; i++) begin
            d = '0;
            for (int j = 0; j < 8; j++) d = {d[55:0], mem[8*i+j]};
            send(d, i == 4, 4'd0, 1'b0, 32'h0);
        end
        wait_out();
    endtask

    initial begin
        #12;
        chk("rst_in_ready", {31'b0, rdy}, 32'd1);
        chk("rst_out_valid", {31'b0, ov}, 32'd0);
        chk("rst_out_crc", ocrc, 32'h0);
        chk("rst_out_len", {16'b0, olen}, 32'd0);
        chk("rst_out_match", {31'b0, om}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_str(1'b0, 32'hCBF43926);
        chk("str_latency", ncyc - t0, 32'd10);
        chk("str_crc", ocrc, 32'hCBF43926);
        chk("str_len", {16'b0, olen}, 32'd9);
        chk("str_nocheck_match", {31'b0, om}, 32'd0);
        take();

        send_str(1'b1, 32'hCBF43926);
        chk("match_good", {31'b0, om}, 32'd1);
        take();
        send_str(1'b1, 32'hCBF43927);
        chk("match_bad", {31'b0, om}, 32'd0);
        take();

        send(64'h0, 1'b1, 4'd1, 1'b0, 32'h0);
        wait_out();
        chk("zero_byte_crc", ocrc, 32'hD202EF8D);
        chk("zero_byte_len", {16'b0, olen}, 32'd1);
        in_data = S1; in_last = 1'b0; in_nbytes = 4'd0; check_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, ov}, 32'd1);
            chk("hold_crc", ocrc, 32'hD202EF8D);
            chk("hold_len", {16'b0, olen}, 32'd1);
            chk("hold_in_ready", {31'b0, rdy}, 32'd0);
        end
        take();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        send(S2, 1'b1, 4'd1, 1'b0, 32'h0);
        wait_out();
        chk("after_hold_crc", ocrc, 32'hCBF43926);
        chk("after_hold_len", {16'b0, olen}, 32'd9);
        take();

        for (int j = 0; j < 8; j++) mem[j] = 8'h31 + 8'(j);
        send(S1, 1'b1, 4'd12, 1'b0, 32'h0);
        wait_out();
        chk("nbytes_over_crc", ocrc, ref_crc(8));
        chk("nbytes_over_len", {16'b0, olen}, 32'd8);
        take();

        send_legacy();
        chk("legacy_len", {16'b0, olen}, 32'd40);
        chk("legacy_crc", ocrc, ref_crc(40));
        take();

        send(S1, 1'b0, 4'd0, 1'b0, 32'h0);
        send(S1, 1'b0, 4'd0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, ov}, 32'd0);
        chk("abort_in_ready", {31'b0, rdy}, 32'd1);
        chk("abort_out_crc", ocrc, 32'h0);
        chk("abort_out_len", {16'b0, olen}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_str(1'b0, 32'h0);
        chk("post_abort_crc", ocrc, 32'hCBF43926);
        chk("post_abort_len", {16'b0, olen}, 32'd9);
        take();

        sel = 1'b1;
        send_str(1'b1, 32'hCBF43926);
        chk("wide_latency", ncyc - t0, 32'd3);
        chk("wide_crc", ocrc, 32'hCBF43926);
        chk("wide_len", {16'b0, olen}, 32'd9);
        chk("wide_match", {31'b0, om}, 32'd1);
        take();
        send_legacy();
        chk("wide_sat_len", {16'b0, olen}, 32'd15);
        chk("wide_sat_crc", ocrc, ref_crc(40));
        take();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
